// File: rtl/pipeline_control.sv
// ---------------------------------------------------------------------------
// pipeline_control
//
// Hazard and stall controller for a five-stage pipeline.
// Each cycle it decides which pipeline latches advance, which latches
// load a bubble, and whether the PC loads. It also keeps two saturating
// performance counters.
//
// State table
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   RUN    | normal operation
//   DHELD  | the MEM-stage data access has already completed, but the pipe is
//          | frozen waiting on ifetch; the memory request is masked so that it
//          | is not issued a second time
//   HALTED | halt reached WB; everything is frozen until reset
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   ihit, dhit           instruction / data access completes this cycle
//   EXMEM_dREN/dWEN      load / store pending in the MEM stage
//   branch_taken, jump   control-flow redirects (branch in EX, jump in ID)
//   StallLW              load-use stall request from the hazard unit
//   MEMWB_halt           halt instruction in WB
//   pc_en, *_en          PC load enable and pipeline latch enables
//   IFID/IDEX_flush      the latch loads a bubble when its enable is 1
//   dmem_mask            the datapath gates dREN/dWEN to memory
//   halt                 registered halted flag
//   stall_cnt, flush_cnt saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_control #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             EXMEM_dREN,
    input  logic             EXMEM_dWEN,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             StallLW,
    input  logic             MEMWB_halt,
    output logic             pc_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             MEMWB_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             dmem_mask,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DHELD  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              halt_q, halt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_op;
    logic dready;
    logic active;

    // Raw control decisions, before the reset gate.
    logic pc_en_c;
    logic ifid_en_c;
    logic idex_en_c;
    logic exmem_en_c;
    logic memwb_en_c;
    logic ifid_flush_c;
    logic idex_flush_c;

    assign mem_op = EXMEM_dREN | EXMEM_dWEN;
    // In DHELD the data access has already completed, so it does not stall us again.
    assign dready = !mem_op || dhit || (state_q == DHELD);
    assign active = (state_q != HALTED);

    always_comb begin
        state_d      = state_q;
        halt_d       = halt_q;
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_en_c    = 1'b0;
        exmem_en_c   = 1'b0;
        memwb_en_c   = 1'b0;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;

        if (active) begin
            if (MEMWB_halt) begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end else if (!dready) begin
                // Data miss: the whole pipe waits.
            end else if (branch_taken && !ihit) begin
                // The redirect must wait for the fetch in flight. If the data
                // access finishes now, remember it so it is not issued again.
                if ((state_q == RUN) && mem_op && dhit) begin
                    state_d = DHELD;
                end
            end else if (!ihit) begin
                idex_en_c    = 1'b1;
                idex_flush_c = 1'b1;
                exmem_en_c   = 1'b1;
                memwb_en_c   = 1'b1;
            end else if (branch_taken) begin
                pc_en_c      = 1'b1;
                ifid_en_c    = 1'b1;
                idex_en_c    = 1'b1;
                exmem_en_c   = 1'b1;
                memwb_en_c   = 1'b1;
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
            end else if (StallLW) begin
                idex_en_c    = 1'b1;
                idex_flush_c = 1'b1;
                exmem_en_c   = 1'b1;
                memwb_en_c   = 1'b1;
            end else if (jump) begin
                pc_en_c      = 1'b1;
                ifid_en_c    = 1'b1;
                idex_en_c    = 1'b1;
                exmem_en_c   = 1'b1;
                memwb_en_c   = 1'b1;
                ifid_flush_c = 1'b1;
            end else begin
                pc_en_c      = 1'b1;
                ifid_en_c    = 1'b1;
                idex_en_c    = 1'b1;
                exmem_en_c   = 1'b1;
                memwb_en_c   = 1'b1;
            end

            // Once the held access has moved past MEM, the mask must drop.
            if ((state_q == DHELD) && !MEMWB_halt && exmem_en_c) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (active) begin
            if (!pc_en_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((ifid_flush_c || idex_flush_c) && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The reset gate keeps every control output low while nRST is held, whatever the inputs do.
    assign pc_en      = nRST & pc_en_c;
    assign IFID_en    = nRST & ifid_en_c;
    assign IDEX_en    = nRST & idex_en_c;
    assign EXMEM_en   = nRST & exmem_en_c;
    assign MEMWB_en   = nRST & memwb_en_c;
    assign IFID_flush = nRST & ifid_flush_c;
    assign IDEX_flush = nRST & idex_flush_c;
    assign dmem_mask  = nRST & (state_q == DHELD);
    assign halt       = halt_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

    // Input bundle, MSB first: ihit dhit dren dwen br jmp lw hlt
    typedef struct packed {
        logic ihit;
        logic dhit;
        logic dren;
        logic dwen;
        logic br;
        logic jmp;
        logic lw;
        logic hlt;
    } in_t;

    // Expected control outputs, MSB first: pc IFID IDEX EXMEM MEMWB IFIDf IDEXf mask
    typedef struct {
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    localparam logic [7:0] O_FREEZE = 8'b0000_0000;
    localparam logic [7:0] O_BUBBLE = 8'b0011_1010;
    localparam logic [7:0] O_SQ2    = 8'b1111_1110;
    localparam logic [7:0] O_SQ1    = 8'b1111_1100;
    localparam logic [7:0] O_GO     = 8'b1111_1000;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, dhit = 1'b0, EXMEM_dREN = 1'b0, EXMEM_dWEN = 1'b0;
    logic branch_taken = 1'b0, jump = 1'b0, StallLW = 1'b0, MEMWB_halt = 1'b0;

    logic a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifidf, a_idexf, a_mask, a_halt;
    logic [15:0] a_stall, a_flush;
    logic b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifidf, b_idexf, b_mask, b_halt;
    logic [3:0] b_stall, b_flush;

    pipeline_control #(.CNT_W(16)) dut16 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .EXMEM_dREN(EXMEM_dREN), .EXMEM_dWEN(EXMEM_dWEN),
        .branch_taken(branch_taken), .jump(jump), .StallLW(StallLW), .MEMWB_halt(MEMWB_halt),
        .pc_en(a_pc), .IFID_en(a_ifid), .IDEX_en(a_idex), .EXMEM_en(a_exmem), .MEMWB_en(a_memwb),
        .IFID_flush(a_ifidf), .IDEX_flush(a_idexf), .dmem_mask(a_mask), .halt(a_halt),
        .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipeline_control #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .EXMEM_dREN(EXMEM_dREN), .EXMEM_dWEN(EXMEM_dWEN),
        .branch_taken(branch_taken), .jump(jump), .StallLW(StallLW), .MEMWB_halt(MEMWB_halt),
        .pc_en(b_pc), .IFID_en(b_ifid), .IDEX_en(b_idex), .EXMEM_en(b_exmem), .MEMWB_en(b_memwb),
        .IFID_flush(b_ifidf), .IDEX_flush(b_idexf), .dmem_mask(b_mask), .halt(b_halt),
        .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: "access already done, waiting on fetch" and "halted".
    bit m_held   = 1'b0;
    bit m_halted = 1'b0;
    int m_st16 = 0, m_fl16 = 0, m_st4 = 0, m_fl4 = 0;
    logic [7:0] last16;

    vec_t tbl[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_out(input in_t i, input bit held, input bit halted);
        logic [6:0] ctl;
        bit ready;
        if (halted) return 8'h00;
        ready = !(i.dren || i.dwen) || i.dhit || held;
        if (i.hlt)                 ctl = O_FREEZE[7:1];
        else if (!ready)           ctl = O_FREEZE[7:1];
        else if (i.br && !i.ihit)  ctl = O_FREEZE[7:1];
        else if (!i.ihit)          ctl = O_BUBBLE[7:1];
        else if (i.br)             ctl = O_SQ2[7:1];
        else if (i.lw)             ctl = O_BUBBLE[7:1];
        else if (i.jmp)            ctl = O_SQ1[7:1];
        else                       ctl = O_GO[7:1];
        return {ctl, held};
    endfunction

    function automatic int sat(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic drive(input in_t i);
        ihit = i.ihit; dhit = i.dhit; EXMEM_dREN = i.dren; EXMEM_dWEN = i.dwen;
        branch_taken = i.br; jump = i.jmp; StallLW = i.lw; MEMWB_halt = i.hlt;
    endtask

    // One cycle: drive just after posedge, compare at negedge, advance model.
    task automatic step(input in_t i);
        logic [7:0] exp;
        logic [7:0] act16, act4;
        drive(i);
        @(negedge CLK);
        exp   = model_out(i, m_held, m_halted);
        act16 = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifidf, a_idexf, a_mask};
        act4  = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifidf, b_idexf, b_mask};
        last16 = act16;
        check("ctl16", {24'd0, act16}, {24'd0, exp});
        check("ctl4",  {24'd0, act4},  {24'd0, exp});
        check("halt16", {31'd0, a_halt}, {31'd0, m_halted});
        check("halt4",  {31'd0, b_halt}, {31'd0, m_halted});
        check("stall16", {16'd0, a_stall}, m_st16);
        check("flush16", {16'd0, a_flush}, m_fl16);
        check("stall4",  {28'd0, b_stall}, m_st4);
        check("flush4",  {28'd0, b_flush}, m_fl4);
        if (!m_halted) begin
            if (!exp[7]) begin
                m_st16 = sat(m_st16, 65535);
                m_st4  = sat(m_st4, 15);
            end
            if (exp[2] || exp[1]) begin
                m_fl16 = sat(m_fl16, 65535);
                m_fl4  = sat(m_fl4, 15);
            end
            if (i.hlt) begin
                m_halted = 1'b1;
            end else if (m_held) begin
                m_held = !exp[4];
            end else begin
                m_held = i.br && !i.ihit && (i.dren || i.dwen) && i.dhit;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // Assert reset with arbitrary inputs present; everything must drop at once.
    task automatic do_reset();
        drive(in_t'($urandom_range(0, 255)));
        nRST = 1'b0;
        #1;
        check("rst_ctl16", {24'd0, a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifidf, a_idexf, a_mask}, 32'd0);
        check("rst_ctl4",  {24'd0, b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifidf, b_idexf, b_mask}, 32'd0);
        check("rst_state16", {a_halt, a_stall, a_flush}, 32'd0);
        check("rst_state4",  {23'd0, b_halt, b_stall, b_flush}, 32'd0);
        m_held = 1'b0; m_halted = 1'b0;
        m_st16 = 0; m_fl16 = 0; m_st4 = 0; m_fl4 = 0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    localparam in_t I_IDLE = in_t'(8'b1000_0000);

    initial begin
        tbl[0]  = '{in_t'(8'b1000_0000), O_GO};
        tbl[1]  = '{in_t'(8'b0000_0000), O_BUBBLE};
        tbl[2]  = '{in_t'(8'b1010_0000), O_FREEZE};
        tbl[3]  = '{in_t'(8'b1110_0000), O_GO};
        tbl[4]  = '{in_t'(8'b1000_1000), O_SQ2};
        tbl[5]  = '{in_t'(8'b0000_1000), O_FREEZE};
        tbl[6]  = '{in_t'(8'b1000_0010), O_BUBBLE};
        tbl[7]  = '{in_t'(8'b1000_0100), O_SQ1};
        tbl[8]  = '{in_t'(8'b1000_0110), O_BUBBLE};
        tbl[9]  = '{in_t'(8'b1000_1010), O_SQ2};
        tbl[10] = '{in_t'(8'b1000_0001), O_FREEZE};
        tbl[11] = '{in_t'(8'b1001_0001), O_FREEZE};
        tbl[12] = '{in_t'(8'b0000_0100), O_BUBBLE};
        tbl[13] = '{in_t'(8'b0101_1000), O_FREEZE};
        tbl[14] = '{in_t'(8'b1001_1000), O_FREEZE};
        tbl[15] = '{in_t'(8'b1101_0100), O_SQ1};

        @(posedge CLK);
        #1;

        for (int k = 0; k < 16; k++) begin
            do_reset();
            step(tbl[k].in);
            check($sformatf("tbl%0d", k), {24'd0, last16}, {24'd0, tbl[k].exp});
        end

        // Ten clean cycles.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(I_IDLE);
            check("clean_ctl", {24'd0, last16}, {24'd0, O_GO});
        end
        check("clean_cnt", {a_stall, a_flush}, 32'd0);

        // Load misses for three cycles, then hits.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(in_t'(8'b1010_0000));
            check("dmiss_freeze", {24'd0, last16}, {24'd0, O_FREEZE});
        end
        step(in_t'(8'b1110_0000));
        check("dmiss_adv", {24'd0, last16}, {24'd0, O_GO});
        check("dmiss_stall", {16'd0, a_stall}, 32'd3);

        // Branch waits on ifetch while the store completes: DHELD, then release.
        do_reset();
        step(in_t'(8'b0101_1000));
        check("dheld_freeze", {24'd0, last16}, {24'd0, O_FREEZE});
        step(in_t'(8'b1101_1000));
        check("dheld_rel", {24'd0, last16}, {24'd0, O_SQ2 | 8'h01});
        step(I_IDLE);
        check("dheld_run", {24'd0, last16}, {24'd0, O_GO});
        check("dheld_flush", {16'd0, a_flush}, 32'd1);

        // Load-use stall for one cycle.
        do_reset();
        step(in_t'(8'b1000_0010));
        check("lw_ctl", {24'd0, last16}, {24'd0, O_BUBBLE});
        check("lw_stall", {16'd0, a_stall}, 32'd1);

        // Halt, stays halted, reset pulse recovers.
        do_reset();
        step(in_t'(8'b1000_0001));
        for (int k = 0; k < 5; k++) begin
            step(I_IDLE);
            check("halt_freeze", {24'd0, last16}, 32'd0);
            check("halt_flag", {31'd0, a_halt}, 32'd1);
        end
        do_reset();
        step(I_IDLE);
        check("halt_recover", {24'd0, last16}, {24'd0, O_GO});

        // Saturation of the narrow counter.
        do_reset();
        for (int k = 0; k < 20; k++) step(in_t'(8'b1000_0010));
        check("sat4", {28'd0, b_stall}, 32'd15);
        check("sat16", {16'd0, a_stall}, 32'd20);

        // Random traffic, including mid-operation resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            in_t r;
            if ($urandom_range(0, 79) == 0) do_reset();
            r.ihit = ($urandom_range(0, 3) != 0);
            r.dhit = $urandom_range(0, 1) != 0;
            r.dren = ($urandom_range(0, 3) == 0);
            r.dwen = ($urandom_range(0, 3) == 0);
            r.br   = ($urandom_range(0, 4) == 0);
            r.jmp  = ($urandom_range(0, 4) == 0);
            r.lw   = ($urandom_range(0, 4) == 0);
            r.hlt  = ($urandom_range(0, 99) == 0);
            step(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
